riscv_crypto_fu_saes32_masked_mlane: RTL and testbench
======================================================

// Module: riscv_crypto_fu_saes32_masked_mlane
// PURPOSE
//  Multi-lane, first-order masked (DOM) AES scalar unit. Successor to the single-byte masked saes32 FU.
//  Adds a word mode that applies SubBytes (+MixColumns) to all 4 bytes of rs2 and XOR-accumulates them.
//  Byte and word modes run on LANES parallel cv32e40x_dom_sbox instances, taking 4/LANES passes.
//  Sits in the X-interface crypto coprocessor between instruction offload and the result bus.
// PARAMETERS
//  X_ID_WIDTH  4  instruction-ID width
//  LANES       1  parallel masked S-boxes; legal values 1, 2, 4 (elaboration error otherwise)
//  SBOX_LAT    4  cv32e40x_dom_sbox valid-in to valid-out latency in cycles; used for bench timing checks only
// PORTS
//  clk_i            in   1              clock
//  rst_n            in   1              async active-low reset
//  valid_i          in   1              request valid
//  ready_i          out  1              unit idle, can accept a request
//  rs1_i            in   32             round-key / accumulator input
//  rs2_i            in   32             state word
//  bs_i             in   2              byte select (byte mode only)
//  word_i           in   1              1 = word mode (all 4 bytes), 0 = byte mode
//  op_decs/op_decsm/op_encs/op_encsm  in  1 each  one-hot op select (sm = with [Inv]MixColumns)
//  randombits_i     in   26*LANES       fresh randomness; lane k uses [26k+25:26k]
//  instr_id_i       in   X_ID_WIDTH     ID tag
//  result_o         out  32             result (recombined unless SAES_SHARE_OUT_EN)
//  result_b_o       out  32             share B of result; tied 0 without SAES_SHARE_OUT_EN
//  instr_id_o       out  X_ID_WIDTH     ID of the result
//  valid_o          out  1              result valid
//  ready_o          in   1              consumer ready
// BEHAVIOUR
//  - Reset rst_n is asynchronous, active-low; clock clk_i. Reset: FSM=IDLE, ready_i=1, valid_o=0, result_o=0, result_b_o=0, instr_id_o=0.
//    All share and accumulator registers reset to 0.
//  - Handshakes: accept on valid_i&&ready_i. Output transfers on valid_o&&ready_o. One op in flight; no overlap.
//  - FSM: IDLE (ready_i=1) -> accept -> ISSUE -> WAIT -> [more passes ? ISSUE : DONE] -> DONE (valid_o=1) -> ready_o -> IDLE.
//  - Accept latches rs1, rs2, bs, mode, ops and ID. It sets accA=rs1, accB=0 and pass=0.
//  - ISSUE (1 cycle) per pass p: lane k processes byte index b = word ? p*LANES+k : bs.
//    Byte mode runs lane 0 only; other lanes get no valid.
//    Lane input shares: A = rs2.byte[b] ^ r, B = r, where r = rand_k[7:0]. rand_k[25:8] goes to the S-box.
//    randombits_i is sampled in ISSUE, fresh for every pass.
//  - WAIT: hold until every active lane returns valid. Then for each lane, per share, build contribution(b):
//    enc: {3s,s,s,2s}; dec: {11s,13s,9s,14s}, written {byte3,byte2,byte1,byte0}. Non-sm ops use {0,0,0,s}.
//    Rotate the contribution left by 8*b bits, matching RISC-V aes32es[m]i/ds[m]i.
//    Update: accA ^= rotA, accB ^= rotB. GF(2^8) mult uses xtime with poly 0x11B.
//  - Passes: byte mode 1; word mode 4/LANES. The pass counter wraps to 0 on entering DONE.
//  - DONE: result_o = accA^accB, instr_id_o = latched ID. Both stay stable while valid_o=1 && ready_o=0.
//  - Shares are never combined before DONE; mux selects act on the mode/op registers, never on share data.
//  - Reset mid-op: all state is discarded immediately; no result is emitted afterwards.
//  - No op bit set, or more than one set, on accept: treated as encs.
//  - Latency accept -> valid_o: passes*(SBOX_LAT+2)+1 cycles max.
// CONFIGURATION
//  - SAES_SHARE_OUT_EN defined: no recombination. result_o=accA, result_b_o=accB; the consumer XORs them.
//  - SAES_SHARE_OUT_EN undefined: result_o=accA^accB, result_b_o=0.
// TESTING
//  1. encs, byte, bs=0, rs1=0, rs2=0x00000000 -> result 0x00000063
//  2. encs, byte, bs=1, rs1=0, rs2=0x00005300 -> result 0x0000ED00
//  3. encsm, byte, bs=0, rs1=0, rs2=0x00000001 -> result 0x847C7CF8
//  4. decs, byte, bs=0, rs1=0xDEADBEEF, rs2=0x00000063 -> result 0xDEADBEEF
//  5. encs, word, rs1=0, rs2=0 for LANES in {1,2,4} -> 0x63636363.
//     Also hold ready_o=0 for 5 cycles: result stable; ready_i=0 throughout.
//  6. Repeat tests 1-5 with random and all-zero randombits: identical results.
//     Assert rst_n mid-WAIT: valid_o=0, ready_i=1 next cycle; the following op is correct.

Source files
------------

// File: rtl/riscv_crypto_fu_saes32_masked_mlane_if.sv
// riscv_crypto_fu_saes32_masked_mlane_if: request/result bundle of the masked multi-lane AES unit
// Request: valid_i/ready_i handshake, rs1_i, rs2_i, bs_i, word_i, op_* one-hot, randombits_i (26 bits per lane), instr_id_i.
// Result: valid_o/ready_o handshake, result_o, result_b_o, instr_id_o.
// master = issuing side (offload logic), slave = the functional unit.
interface riscv_crypto_fu_saes32_masked_mlane_if #(
  parameter int X_ID_WIDTH = 4,
  parameter int LANES = 1
);
  logic valid_i, ready_i, word_i, op_decs, op_decsm, op_encs, op_encsm, valid_o, ready_o;
  logic [31:0] rs1_i, rs2_i, result_o, result_b_o;
  logic [1:0] bs_i;
  logic [26*LANES-1:0] randombits_i;
  logic [X_ID_WIDTH-1:0] instr_id_i, instr_id_o;
  modport master (
    output valid_i, rs1_i, rs2_i, bs_i, word_i, op_decs, op_decsm, op_encs, op_encsm,
           randombits_i, instr_id_i, ready_o,
    input  ready_i, result_o, result_b_o, instr_id_o, valid_o
  );
  modport slave (
    input  valid_i, rs1_i, rs2_i, bs_i, word_i, op_decs, op_decsm, op_encs, op_encsm,
           randombits_i, instr_id_i, ready_o,
    output ready_i, result_o, result_b_o, instr_id_o, valid_o
  );
endinterface

// File: rtl/riscv_crypto_fu_saes32_masked_mlane.sv
// riscv_crypto_fu_saes32_masked_mlane: first-order DOM-masked AES32 unit (byte or full-word SubBytes[+MixColumns])
// Ports: clk_i, rst_n (async, active-low), bus (slave modport of riscv_crypto_fu_saes32_masked_mlane_if).
// LANES masked S-boxes (1/2/4) run 4/LANES passes in word mode, one pass in byte mode.
// Option macro SAES_SHARE_OUT_EN: output both shares (result_o=A, result_b_o=B) instead of recombining.
module riscv_crypto_fu_saes32_masked_mlane #(
  parameter int X_ID_WIDTH = 4,
  parameter int LANES = 1,
  parameter int SBOX_LAT = 4
) (
  input logic clk_i,
  input logic rst_n,
  riscv_crypto_fu_saes32_masked_mlane_if.slave bus
);
  localparam int NPASS = 4 / LANES;
  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("LANES must be 1, 2 or 4");
  end
  if (SBOX_LAT != 4) begin : g_bad_lat
    $error("masked S-box pipeline has exactly 4 stages");
  end
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      p ^= b[i] ? t : 8'h00;
      t = xt(t);
    end
    return p;
  endfunction
  function automatic logic [7:0] sq(input logic [7:0] x);
    return gm(x, x);
  endfunction
  function automatic logic [7:0] rl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction
  function automatic logic [7:0] aff(input logic [7:0] x);
    return x ^ rl8(x, 1) ^ rl8(x, 2) ^ rl8(x, 3) ^ rl8(x, 4);
  endfunction
  function automatic logic [7:0] iaff(input logic [7:0] x);
    return rl8(x, 1) ^ rl8(x, 3) ^ rl8(x, 6);
  endfunction
  // DOM multiply: each domain adds its cross term under the same fresh mask z.
  function automatic logic [15:0] dmul(input logic [7:0] a0, a1, b0, b1, z);
    return {gm(a0, b0) ^ gm(a0, b1) ^ z, gm(a1, b1) ^ gm(a1, b0) ^ z};
  endfunction
  function automatic logic [31:0] contrib(input logic [7:0] s, input logic enc, input logic sm);
    return !sm ? {24'h0, s} : enc ? {gm(s, 8'h03), s, s, gm(s, 8'h02)}
                                  : {gm(s, 8'h0b), gm(s, 8'h0d), gm(s, 8'h09), gm(s, 8'h0e)};
  endfunction
  function automatic logic [31:0] rot32(input logic [31:0] c, input logic [1:0] b);
    logic [63:0] d;
    d = {c, c} << {b, 3'b000};
    return d[63:32];
  endfunction
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nxt;
  logic [31:0] rs2_q, acc_a, acc_b, upd_a, upd_b;
  logic [1:0] bs_q, pass_q;
  logic word_q, enc_q, sm_q, accept, issue, all_done, last, onehot;
  logic [X_ID_WIDTH-1:0] id_q;
  logic [LANES-1:0] lane_en, lane_ok;
  logic [LANES-1:0][31:0] rot_a, rot_b;
  assign accept = bus.valid_i && bus.ready_i;
  assign last = !word_q || pass_q == 2'(NPASS - 1);
  assign all_done = &lane_ok;
  assign onehot = $onehot({bus.op_decs, bus.op_decsm, bus.op_encs, bus.op_encsm});
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.valid_i ? ISSUE : IDLE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = all_done ? (last ? DONE : ISSUE) : WAIT;
      DONE:    state_nxt = bus.ready_o ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.ready_i = state == IDLE;
    bus.valid_o = state == DONE;
    issue = state == ISSUE;
    bus.instr_id_o = state == DONE ? id_q : '0;
`ifdef SAES_SHARE_OUT_EN
    bus.result_o = state == DONE ? acc_a : '0;
    bus.result_b_o = state == DONE ? acc_b : '0;
`else
    bus.result_o = state == DONE ? acc_a ^ acc_b : '0;
    bus.result_b_o = '0;
`endif
  end
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      rs2_q <= '0;
      bs_q <= '0;
      word_q <= 1'b0;
      enc_q <= 1'b1;
      sm_q <= 1'b0;
      id_q <= '0;
      acc_a <= '0;
      acc_b <= '0;
      pass_q <= '0;
    end else if (accept) begin
      rs2_q <= bus.rs2_i;
      bs_q <= bus.bs_i;
      word_q <= bus.word_i;
      enc_q <= !(onehot && (bus.op_decs || bus.op_decsm));
      sm_q <= onehot && (bus.op_encsm || bus.op_decsm);
      id_q <= bus.instr_id_i;
      acc_a <= bus.rs1_i;
      acc_b <= '0;
      pass_q <= '0;
    end else if (state == WAIT && all_done) begin
      acc_a <= acc_a ^ upd_a;
      acc_b <= acc_b ^ upd_b;
      pass_q <= last ? 2'd0 : pass_q + 2'd1;
    end
  always_comb begin
    upd_a = '0;
    upd_b = '0;
    for (int k = 0; k < LANES; k++) begin
      upd_a ^= lane_en[k] ? rot_a[k] : '0;
      upd_b ^= lane_en[k] ? rot_b[k] : '0;
    end
  end
  // Masked S-box per lane: inversion as x^254 = x2*x252 using four DOM multiplies, one register stage each.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [1:0] b;
    logic [3:0] v;
    logic [17:0] rz;
    logic [15:0] m1, m2, m3, m4;
    logic [7:0] r0, a_in, ia, ib, x2a, x2b, t12a, t12b, t240a, t240b, oa, ob;
    logic [7:0] q1_ya, q1_yb, q1_sa, q1_sb, q1_z2, q1_z3, q1_z4;
    logic [7:0] q2_ya, q2_yb, q2_ta, q2_tb, q2_sa, q2_sb, q2_z3, q2_z4;
    logic [7:0] q3_ya, q3_yb, q3_sa, q3_sb, q3_z4, q4_ya, q4_yb;
    assign b = word_q ? 2'(int'(pass_q) * LANES + k) : bs_q;
    assign lane_en[k] = word_q || k == 0;
    assign lane_ok[k] = v[3] || !lane_en[k];
    assign r0 = bus.randombits_i[26*k +: 8];
    assign rz = bus.randombits_i[26*k+8 +: 18];
    assign a_in = rs2_q[{b, 3'b000} +: 8] ^ r0;
    // Affine maps are linear per share; only share A carries the affine constant.
    assign ia = enc_q ? a_in : iaff(a_in) ^ 8'h05;
    assign ib = enc_q ? r0 : iaff(r0);
    assign x2a = sq(ia);
    assign x2b = sq(ib);
    assign m1 = dmul(ia, ib, x2a, x2b, rz[7:0]);
    assign t12a = sq(sq(q1_ya));
    assign t12b = sq(sq(q1_yb));
    assign m2 = dmul(q1_ya, q1_yb, t12a, t12b, q1_z2);
    assign t240a = sq(sq(sq(sq(q2_ya))));
    assign t240b = sq(sq(sq(sq(q2_yb))));
    assign m3 = dmul(t240a, t240b, q2_ta, q2_tb, q2_z3);
    assign m4 = dmul(q3_ya, q3_yb, q3_sa, q3_sb, q3_z4);
    assign oa = enc_q ? aff(q4_ya) ^ 8'h63 : q4_ya;
    assign ob = enc_q ? aff(q4_yb) : q4_yb;
    assign rot_a[k] = rot32(contrib(oa, enc_q, sm_q), b);
    assign rot_b[k] = rot32(contrib(ob, enc_q, sm_q), b);
    always_ff @(posedge clk_i or negedge rst_n)
      if (!rst_n) begin
        v <= '0;
        {q1_ya, q1_yb, q1_sa, q1_sb, q1_z2, q1_z3, q1_z4} <= '0;
        {q2_ya, q2_yb, q2_ta, q2_tb, q2_sa, q2_sb, q2_z3, q2_z4} <= '0;
        {q3_ya, q3_yb, q3_sa, q3_sb, q3_z4, q4_ya, q4_yb} <= '0;
      end else begin
        v <= {v[2:0], issue && lane_en[k]};
        {q1_ya, q1_yb, q1_sa, q1_sb} <= {m1, x2a, x2b};
        {q1_z2, q1_z3, q1_z4} <= {rz[15:8], rz[17:16], rz[5:0], rz[13:6]};
        {q2_ya, q2_yb, q2_ta, q2_tb} <= {m2, t12a, t12b};
        {q2_sa, q2_sb, q2_z3, q2_z4} <= {q1_sa, q1_sb, q1_z3, q1_z4};
        {q3_ya, q3_yb, q3_sa, q3_sb, q3_z4} <= {m3, q2_sa, q2_sb, q2_z4};
        {q4_ya, q4_yb} <= m4;
      end
  end
endmodule

// File: tb/tb_riscv_crypto_fu_saes32_masked_mlane.sv
// tb_riscv_crypto_fu_saes32_masked_mlane: directed checks of the masked AES32 unit for LANES = 1, 2 and 4 side by side
module tb_riscv_crypto_fu_saes32_masked_mlane;
  localparam logic [3:0] DECS = 4'b1000, DECSM = 4'b0100, ENCS = 4'b0010, ENCSM = 4'b0001;
  logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, word = 1'b0, ready_o = 1'b0;
  logic [3:0] ops = '0, id = '0;
  logic [1:0] bs = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [103:0] rnd = '0;
  logic [2:0] v_o, r_i;
  logic [31:0] res [3];
  logic [31:0] resb [3];
  logic [3:0] ido [3];
  bit zero_rand = 1'b0;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = 1 << g;
    riscv_crypto_fu_saes32_masked_mlane_if #(.X_ID_WIDTH(4), .LANES(L)) bus ();
    assign bus.valid_i = valid;
    assign bus.rs1_i = rs1;
    assign bus.rs2_i = rs2;
    assign bus.bs_i = bs;
    assign bus.word_i = word;
    assign {bus.op_decs, bus.op_decsm, bus.op_encs, bus.op_encsm} = ops;
    assign bus.randombits_i = rnd[26*L-1:0];
    assign bus.instr_id_i = id;
    assign bus.ready_o = ready_o;
    assign v_o[g] = bus.valid_o;
    assign r_i[g] = bus.ready_i;
    assign res[g] = bus.result_o;
    assign resb[g] = bus.result_b_o;
    assign ido[g] = bus.instr_id_o;
    riscv_crypto_fu_saes32_masked_mlane #(.X_ID_WIDTH(4), .LANES(L), .SBOX_LAT(4)) dut (
      .clk_i(clk),
      .rst_n(rst_n),
      .bus(bus)
    );
  end
  task automatic new_rand();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    rnd = zero_rand ? '0 : t[103:0];
  endtask
  task automatic run_op(input string nm, input logic [3:0] op, input logic w, input logic [1:0] b,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [3:0] tag,
                        input logic [31:0] exp, input int hold);
    int c;
    int fst [3];
    fst = '{0, 0, 0};
    ops = op; word = w; bs = b; rs1 = r1; rs2 = r2; id = tag; valid = 1'b1;
    new_rand();
    n_cmp++;
    if (r_i !== 3'b111) begin n_bad++; $display("FAIL %s ready_i before accept: got %b want 111", nm, r_i); end
    @(posedge clk); #1;
    valid = 1'b0; ops = '0; word = ~w; bs = ~b; rs1 = '1; rs2 = '1; id = ~tag;
    c = 0;
    while (v_o !== 3'b111 && c < 40) begin
      @(posedge clk); #1;
      c++;
      new_rand();
      for (int j = 0; j < 3; j++) if (v_o[j] === 1'b1 && fst[j] == 0) fst[j] = c;
    end
    for (int j = 0; j < 3; j++) begin
      n_cmp++;
      if (v_o[j] !== 1'b1 || fst[j] > (w ? 4 >> j : 1) * 6 + 1) begin
        n_bad++; $display("FAIL %s latency lanes=%0d: valid_o=%b after %0d cycles, want <= %0d", nm, 1 << j, v_o[j], fst[j], (w ? 4 >> j : 1) * 6 + 1);
      end
      n_cmp++;
      if (res[j] !== exp) begin n_bad++; $display("FAIL %s result lanes=%0d: got %h want %h", nm, 1 << j, res[j], exp); end
      n_cmp++;
      if (resb[j] !== 32'h0) begin n_bad++; $display("FAIL %s result_b lanes=%0d: got %h want 0", nm, 1 << j, resb[j]); end
      n_cmp++;
      if (ido[j] !== tag) begin n_bad++; $display("FAIL %s instr_id lanes=%0d: got %h want %h", nm, 1 << j, ido[j], tag); end
      n_cmp++;
      if (r_i[j] !== 1'b0) begin n_bad++; $display("FAIL %s ready_i busy lanes=%0d: got %b want 0", nm, 1 << j, r_i[j]); end
    end
    repeat (hold) begin
      @(posedge clk); #1;
      new_rand();
      for (int j = 0; j < 3; j++) begin
        n_cmp++;
        if (v_o[j] !== 1'b1 || r_i[j] !== 1'b0 || res[j] !== exp || ido[j] !== tag) begin
          n_bad++; $display("FAIL %s stall lanes=%0d: valid=%b ready=%b res=%h id=%h want 1 0 %h %h", nm, 1 << j, v_o[j], r_i[j], res[j], ido[j], exp, tag);
        end
      end
    end
    ready_o = 1'b1;
    @(posedge clk); #1;
    ready_o = 1'b0;
    n_cmp++;
    if (v_o !== 3'b000 || r_i !== 3'b111) begin n_bad++; $display("FAIL %s release: valid_o=%b ready_i=%b want 000 111", nm, v_o, r_i); end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < 3; j++) begin
        n_cmp++;
        if (v_o[j] !== 1'b0 || r_i[j] !== 1'b1 || res[j] !== 32'h0 || resb[j] !== 32'h0 || ido[j] !== 4'h0) begin
          n_bad++; $display("FAIL reset%0d lanes=%0d: valid=%b ready=%b res=%h resb=%h id=%h want 0 1 0 0 0", p, 1 << j, v_o[j], r_i[j], res[j], resb[j], ido[j]);
        end
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
    end
  endtask
  task automatic test_byte_ops();
    run_op("encs_b0", ENCS, 1'b0, 2'd0, 32'h0, 32'h00000000, 4'h1, 32'h00000063, 0);
    run_op("encs_b1", ENCS, 1'b0, 2'd1, 32'h0, 32'h00005300, 4'h2, 32'h0000ED00, 0);
    run_op("encsm_b0", ENCSM, 1'b0, 2'd0, 32'h0, 32'h00000001, 4'h3, 32'h847C7CF8, 0);
    run_op("decs_b0", DECS, 1'b0, 2'd0, 32'hDEADBEEF, 32'h00000063, 4'h4, 32'hDEADBEEF, 0);
    run_op("decsm_b2", DECSM, 1'b0, 2'd2, 32'h0, 32'h007C0000, 4'h5, 32'h090E0B0D, 0);
    run_op("encs_b3_acc", ENCS, 1'b0, 2'd3, 32'h000000FF, 32'h53000000, 4'h6, 32'hED0000FF, 0);
    run_op("noop_b3", 4'b0000, 1'b0, 2'd3, 32'h0, 32'h0, 4'h7, 32'h63000000, 0);
    run_op("multiop_b0", DECS | ENCSM, 1'b0, 2'd0, 32'h0, 32'h0, 4'h8, 32'h00000063, 0);
  endtask
  task automatic test_word();
    run_op("encs_w_hold", ENCS, 1'b1, 2'd0, 32'h0, 32'h0, 4'h9, 32'h63636363, 5);
    run_op("encs_w_mix", ENCS, 1'b1, 2'd2, 32'h0, 32'h00010053, 4'hA, 32'h637C63ED, 0);
    run_op("decs_w", DECS, 1'b1, 2'd1, 32'h12345678, 32'h63636363, 4'hB, 32'h12345678, 0);
    run_op("encsm_w", ENCSM, 1'b1, 2'd3, 32'h0, 32'h0, 4'hC, 32'h63636363, 0);
  endtask
  task automatic test_zero_rand();
    zero_rand = 1'b1;
    run_op("z_encs_b1", ENCS, 1'b0, 2'd1, 32'h0, 32'h00005300, 4'h2, 32'h0000ED00, 0);
    run_op("z_encsm_b0", ENCSM, 1'b0, 2'd0, 32'h0, 32'h00000001, 4'h3, 32'h847C7CF8, 0);
    run_op("z_decs_b0", DECS, 1'b0, 2'd0, 32'hDEADBEEF, 32'h00000063, 4'h4, 32'hDEADBEEF, 0);
    run_op("z_encs_w", ENCS, 1'b1, 2'd0, 32'h0, 32'h0, 4'h9, 32'h63636363, 2);
    run_op("z_encs_w_mix", ENCS, 1'b1, 2'd0, 32'h0, 32'h00010053, 4'hA, 32'h637C63ED, 0);
    zero_rand = 1'b0;
  endtask
  task automatic test_reset_mid_op();
    bit seen;
    ops = ENCS; word = 1'b1; bs = 2'd0; rs1 = 32'h0; rs2 = 32'h0; id = 4'hE; valid = 1'b1;
    new_rand();
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; new_rand(); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (v_o !== 3'b000 || r_i !== 3'b111) begin n_bad++; $display("FAIL midrst_async: valid_o=%b ready_i=%b want 000 111", v_o, r_i); end
    @(posedge clk); #1;
    n_cmp++;
    if (v_o !== 3'b000 || r_i !== 3'b111) begin n_bad++; $display("FAIL midrst_next: valid_o=%b ready_i=%b want 000 111", v_o, r_i); end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (v_o !== 3'b000) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin n_bad++; $display("FAIL midrst_no_result: valid_o rose after reset, want 0"); end
    run_op("after_rst", ENCSM, 1'b0, 2'd0, 32'h0, 32'h00000001, 4'hF, 32'h847C7CF8, 0);
  endtask
  initial begin
    test_reset();
    test_byte_ops();
    test_word();
    test_zero_rand();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
